// File: rtl/multi_toggle_sync_rx.sv
// Multi-channel toggle-event receiver: synchronise, edge-detect, acknowledge.
// Optional saturating clear-on-read event counters when EVENT_CNT_EN is defined.
module multi_toggle_sync_rx #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  localparam int RSEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_dst_clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_async_tgl,
  output logic [NUM_CH-1:0] o_pulse,
  output logic [NUM_CH-1:0] o_ack_tgl,
  input  logic              i_rd_en,
  input  logic [RSEL_W-1:0] i_rd_sel,
  output logic              o_rd_valid,
  output logic [CNT_W:0]    o_rd_data
);

  // Sync chain and history flops must stay in place for metastability settling.
  (* async_reg = "true", keep = "true" *) logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  (* async_reg = "true", keep = "true" *) logic [NUM_CH-1:0] hist_q;
  logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
  logic [NUM_CH-1:0] hist_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;

  always_comb begin
    sync_d[0] = i_async_tgl;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    hist_d  = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] ^ hist_q;
  end

  always_ff @(posedge i_dst_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      hist_q  <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse   = pulse_q;
  assign o_ack_tgl = hist_q;

`ifdef EVENT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W:0]    rd_data_q, rd_data_d;

  // A read returns the pre-update value; a coinciding event restarts the count at 1.
  always_comb begin
    rd_valid_d = i_rd_en;
    rd_data_d  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      ovf_d[k] = ovf_q[k];
      if (i_rd_en && (i_rd_sel == RSEL_W'(k))) begin
        rd_data_d = {ovf_q[k], cnt_q[k]};
        cnt_d[k]  = pulse_q[k] ? CNT_W'(1) : '0;
        ovf_d[k]  = 1'b0;
      end else if (pulse_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          ovf_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_dst_clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
      end
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
`else
  logic unused_rd;
  assign unused_rd  = ^{i_rd_en, i_rd_sel};
  assign o_rd_valid = 1'b0;
  assign o_rd_data  = '0;
`endif

endmodule

// File: tb/tb_multi_toggle_sync_rx.sv
// Bench for multi_toggle_sync_rx: a 4-channel/8-bit instance and a 3-channel/2-bit
// instance share stimulus; pulses, acks and reads are checked from scoreboard queues.
module tb_multi_toggle_sync_rx;
  localparam int LAT = 3;  // SYNC_STAGES + 1

  logic       clk;
  logic       rst;
  logic [3:0] tgl;
  logic       rd_en;
  logic [1:0] rd_sel;

  logic [3:0] pulse8, ack8;
  logic       rd_valid8;
  logic [8:0] rd_data8;
  logic [2:0] pulse2, ack2;
  logic       rd_valid2;
  logic [2:0] rd_data2;

  multi_toggle_sync_rx #(.NUM_CH(4), .SYNC_STAGES(2), .CNT_W(8)) dut8 (
    .i_dst_clk(clk), .rst(rst), .i_async_tgl(tgl), .o_pulse(pulse8), .o_ack_tgl(ack8),
    .i_rd_en(rd_en), .i_rd_sel(rd_sel), .o_rd_valid(rd_valid8), .o_rd_data(rd_data8));

  multi_toggle_sync_rx #(.NUM_CH(3), .SYNC_STAGES(2), .CNT_W(2)) dut2 (
    .i_dst_clk(clk), .rst(rst), .i_async_tgl(tgl[2:0]), .o_pulse(pulse2), .o_ack_tgl(ack2),
    .i_rd_en(rd_en), .i_rd_sel(rd_sel), .o_rd_valid(rd_valid2), .o_rd_data(rd_data2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [3:0] mask;} pev_t;
  typedef struct {int cyc; logic [8:0] d8; logic [2:0] d2;} rev_t;
  pev_t pq[$];
  rev_t rq[$];
  pev_t pe;
  rev_t re;
  logic [3:0] ack_exp = '0;
  logic [3:0] ep;
  logic       ev;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ep = '0;
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      pe = pq.pop_front();
      ep ^= pe.mask;
    end
    ack_exp ^= ep;
    chk("pulse8", 32'(pulse8), 32'(ep));
    chk("ack8", 32'(ack8), 32'(ack_exp));
    chk("pulse2", 32'(pulse2), 32'(ep[2:0]));
    chk("ack2", 32'(ack2), 32'(ack_exp[2:0]));
    ev = (rq.size() > 0) && (rq[0].cyc <= cyc);
    chk("rd_valid8", 32'(rd_valid8), 32'(ev));
    chk("rd_valid2", 32'(rd_valid2), 32'(ev));
    if (ev) begin
      re = rq.pop_front();
      chk("rd_data8", 32'(rd_data8), 32'(re.d8));
      chk("rd_data2", 32'(rd_data2), 32'(re.d2));
    end
`ifndef EVENT_CNT_EN
    chk("rd_data8_tied", 32'(rd_data8), 32'd0);
    chk("rd_data2_tied", 32'(rd_data2), 32'd0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic toggle(input logic [3:0] mask);
    pev_t p;
    tick();
    tgl ^= mask;
    p.cyc = cyc + LAT;
    p.mask = mask;
    pq.push_back(p);
  endtask

  task automatic rd(input logic [1:0] sel, input logic [8:0] e8, input logic [2:0] e2);
    rev_t r;
    tick();
    rd_en  = 1'b1;
    rd_sel = sel;
    r.cyc = cyc + 1;
    r.d8  = e8;
    r.d2  = e2;
`ifdef EVENT_CNT_EN
    rq.push_back(r);
`endif
  endtask

  // Source and destination resets release together, so the source level is set during reset.
  task automatic do_reset(input logic [3:0] new_tgl);
    pev_t p;
    tick();
    rst = 1'b1;
    tgl = new_tgl;
    pq.delete();
    rq.delete();
    ack_exp = '0;
    idle(3);
    tick();
    rst = 1'b0;
    if (new_tgl != 4'd0) begin
      p.cyc = cyc + LAT;
      p.mask = new_tgl;
      pq.push_back(p);
    end
  endtask

  typedef enum logic {S_TGL, S_RD} kind_e;
  typedef struct {kind_e kind; logic [3:0] arg; int gap; logic [8:0] e8; logic [2:0] e2;} step_t;
  step_t tbl[7];

  initial begin
    tbl[0] = '{S_TGL, 4'hF, 10, 9'd0, 3'd0};
    tbl[1] = '{S_TGL, 4'hF, 10, 9'd0, 3'd0};
    tbl[2] = '{S_RD,  4'd0, 0,  9'd2, 3'd2};
    tbl[3] = '{S_RD,  4'd1, 0,  9'd2, 3'd2};
    tbl[4] = '{S_RD,  4'd2, 0,  9'd2, 3'd2};
    tbl[5] = '{S_RD,  4'd3, 0,  9'd2, 3'd0};  // dut2: channel 3 is out of range
    tbl[6] = '{S_RD,  4'd0, 0,  9'd0, 3'd0};

    rst = 1'b0; tgl = '0; rd_en = 1'b0; rd_sel = '0;
    #1 rst = 1'b1;
    do_reset(4'd0);
    idle(4);

    // Single event on channel 0, then clear it.
    toggle(4'b0001);
    idle(6);
    rd(2'd0, 9'd1, 3'd1);
    idle(3);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].kind == S_TGL) toggle(tbl[i].arg);
      else rd(tbl[i].arg[1:0], tbl[i].e8, tbl[i].e2);
      idle(tbl[i].gap);
    end
    idle(3);

    // Five events on channel 2: dut2 saturates at 3 with overflow.
    for (int i = 0; i < 5; i++) begin
      toggle(4'b0100);
      idle(5);
    end
    idle(2);
    rd(2'd2, 9'd5, 3'b111);
    rd(2'd2, 9'd0, 3'b000);
    idle(3);

    // Four events on channel 1, then a fifth whose pulse coincides with the read.
    for (int i = 0; i < 4; i++) begin
      toggle(4'b0010);
      idle(5);
    end
    idle(2);
    toggle(4'b0010);
    idle(LAT - 1);
    rd(2'd1, 9'd4, 3'b111);
    idle(5);
    rd(2'd1, 9'd1, 3'd1);
    idle(3);

    // Out-of-range select on dut2 must not disturb channel 0.
    toggle(4'b0001);
    idle(6);
    rd(2'd3, 9'd0, 3'd0);
    rd(2'd0, 9'd1, 3'd1);
    idle(3);

    // Reset while an event is still in the sync chain.
    toggle(4'b0010);
    idle(1);
    do_reset(4'd0);
    idle(8);
    rd(2'd1, 9'd0, 3'd0);
    idle(3);

    // Level held high across reset release gives one event on channel 3.
    do_reset(4'b1000);
    idle(8);
    rd(2'd3, 9'd1, 3'd0);
    idle(6);

    chk("pulse_queue_drained", 32'(pq.size()), 32'd0);
    chk("read_queue_drained", 32'(rq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
